// File: rtl/instr_fetch_responder_if.sv
// rtl/instr_fetch_responder_if.sv - fetch request/response handshake bundle
interface instr_fetch_responder_if #(
  parameter int AddrSize = 32,
  parameter int DataSize = 32
);
  logic                req_valid;
  logic                req_ready;
  logic [AddrSize-1:0] req_addr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_err;
  logic [DataSize-1:0] rsp_instr;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_err
  );
endinterface

// File: rtl/instr_fetch_responder.sv
// rtl/instr_fetch_responder.sv - instruction memory responder with fixed-latency pipeline
// Credit-gated acceptance keeps the response queue from ever overflowing.
module instr_fetch_responder #(
  parameter int AddrSize = 32,
  parameter int DataSize = 32,
  parameter int Depth    = 1024,
  parameter int Latency  = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  instr_fetch_responder_if.slave     bus,
  input  logic                       flush,
  input  logic                       ld_en,
  input  logic [$clog2(Depth)-1:0]   ld_addr,
  input  logic [DataSize-1:0]        ld_data
);
  localparam int IdxW = $clog2(Depth);
  localparam int PtrW = (Latency > 1) ? $clog2(Latency) : 1;
  localparam int CntW = $clog2(Latency + 1);
  localparam logic [DataSize-1:0] Nop    = DataSize'(32'h0000_0013);
  localparam logic [AddrSize-1:0] DepthA = AddrSize'(Depth);
  localparam logic [CntW-1:0]     LatC   = CntW'(Latency);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Latency - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [DataSize-1:0] mem_q [Depth];

  logic                req_ready;
  logic                rsp_valid;
  logic                accept;
  logic                pop;
  logic                misaligned;
  logic                out_of_range;
  logic [IdxW-1:0]     rd_idx;
  logic                in_err;
  logic [DataSize-1:0] in_instr;
  logic                out_valid;
  logic                out_err;
  logic [DataSize-1:0] out_instr;
  logic                q_wr;

  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [CntW-1:0]     outst_q, outst_d;
  logic                rst_done_q;
  logic [DataSize-1:0] q_instr_q [Latency];
  logic                q_err_q   [Latency];

  // Program load; the array is deliberately left out of reset so code survives a core reset.
  always_ff @(posedge clk) begin
    if (ld_en) mem_q[ld_addr] <= ld_data;
  end

  // The full address is compared so high PC bits never alias onto a valid index.
  assign misaligned   = |bus.req_addr[1:0];
  assign out_of_range = (bus.req_addr >> 2) >= DepthA;
  assign rd_idx       = bus.req_addr[IdxW+1:2];
  assign in_err       = misaligned | out_of_range;
  assign in_instr     = in_err ? Nop : mem_q[rd_idx];

  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid && bus.rsp_ready;
  assign req_ready = rst_done_q && !flush && ((outst_q < LatC) || pop);
  assign accept    = bus.req_valid && req_ready;

  generate
    if (Latency > 1) begin : g_pipe
      localparam int Stages = Latency - 1;
      logic                pv_q [Stages];
      logic                pv_d [Stages];
      logic                pe_q [Stages];
      logic                pe_d [Stages];
      logic [DataSize-1:0] pi_q [Stages];
      logic [DataSize-1:0] pi_d [Stages];

      always_comb begin
        pv_d[0] = accept;
        pe_d[0] = in_err;
        pi_d[0] = in_instr;
        for (int k = 1; k < Stages; k++) begin
          pv_d[k] = pv_q[k-1];
          pe_d[k] = pe_q[k-1];
          pi_d[k] = pi_q[k-1];
        end
        if (flush) begin
          for (int k = 0; k < Stages; k++) pv_d[k] = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < Stages; k++) begin
            pv_q[k] <= 1'b0;
            pe_q[k] <= 1'b0;
            pi_q[k] <= '0;
          end
        end else begin
          pv_q <= pv_d;
          pe_q <= pe_d;
          pi_q <= pi_d;
        end
      end

      assign out_valid = pv_q[Stages-1];
      assign out_err   = pe_q[Stages-1];
      assign out_instr = pi_q[Stages-1];
    end else begin : g_direct
      assign out_valid = accept;
      assign out_err   = in_err;
      assign out_instr = in_instr;
    end
  endgenerate

  assign q_wr = out_valid && !flush;

  always_ff @(posedge clk) begin
    if (q_wr) begin
      q_instr_q[wr_ptr_q] <= out_instr;
      q_err_q[wr_ptr_q]   <= out_err;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    outst_d  = outst_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      outst_d  = '0;
    end else begin
      if (q_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(q_wr) - CntW'(pop);
      outst_d = outst_q + CntW'(accept) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      rst_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      rst_done_q <= 1'b1;
    end
  end

  // Head data is gated so the outputs read zero whenever the queue is empty or in reset.
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_instr = rsp_valid ? q_instr_q[rd_ptr_q] : '0;
  assign bus.rsp_err   = rsp_valid && q_err_q[rd_ptr_q];

  a_outstanding_bound: assert property (@(posedge clk) disable iff (!reset_n)
    (outst_q <= LatC) && (count_q <= outst_q));
endmodule

// File: tb/tb_instr_fetch_responder.sv
// tb/tb_instr_fetch_responder.sv - scoreboard bench for instr_fetch_responder
module tb_instr_fetch_responder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  always #5 clk = ~clk;

  instr_fetch_responder_if #(.AddrSize(32), .DataSize(32)) bus ();

  instr_fetch_responder #(
    .AddrSize(32), .DataSize(32), .Depth(1024), .Latency(2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .flush   (flush),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          acc;
    bit          exact;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        held_v = 1'b0;
  logic [31:0] held_i;
  logic        held_e;
  logic [31:0] tbl [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks head stability under backpressure.
  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got instr %h err %0b, expected no response",
                 bus.rsp_instr, bus.rsp_err);
      end else begin
        e = sb.pop_front();
        chk("rsp_instr", bus.rsp_instr, e.instr);
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        if (e.exact) chk("rsp_latency", 32'(cyc - e.acc), 32'd2);
      end
      held_v = 1'b0;
    end else if (bus.rsp_valid) begin
      if (held_v) begin
        chk("hold_instr", bus.rsp_instr, held_i);
        chk("hold_err", 32'(bus.rsp_err), 32'(held_e));
      end
      held_v = 1'b1;
      held_i = bus.rsp_instr;
      held_e = bus.rsp_err;
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] ei, input logic ee,
                       input bit exact, output bit acc);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    @(negedge clk);
    acc = bus.req_ready;
    if (acc) sb.push_back('{ei, ee, cyc, exact});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ee);
    bit acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      issue(a, ei, ee, 1'b0, acc);
      if (acc) break;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL fetch_accept: addr %h never accepted, expected accept", a);
    end
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit acc;
    int n;
    tbl[0] = 32'h11; tbl[1] = 32'h22; tbl[2] = 32'h33; tbl[3] = 32'h44;
    reset_n = 1'b0; flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset_rsp_instr", bus.rsp_instr, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 4; i++) load(10'(i), tbl[i]);
    load(10'd1023, 32'hDEAD_BEEF);

    // Back-to-back fetches with exact two-cycle latency
    for (int i = 0; i < 4; i++) begin
      issue(32'(i * 4), tbl[i], 1'b0, 1'b1, acc);
      chk("b2b_ready", 32'(acc), 32'd1);
    end
    drain();

    // Error and boundary addresses
    fetch(32'h0000_0006, 32'h13, 1'b1);
    fetch(32'h0000_1000, 32'h13, 1'b1);
    fetch(32'h0000_0FFC, 32'hDEAD_BEEF, 1'b0);
    fetch(32'h8000_0000, 32'h13, 1'b1);
    fetch(32'h0000_1001, 32'h13, 1'b1);
    drain();

    // Backpressure: only Latency requests fit
    bus.rsp_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      issue(32'(i * 4), tbl[i], 1'b0, 1'b0, acc);
      n += int'(acc);
    end
    chk("bp_accepted", 32'(n), 32'd2);
    chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    drain();
    chk("bp_ready_back", 32'(bus.req_ready), 32'd1);

    // Flush with two in flight and a competing request
    bus.rsp_ready = 1'b0;
    issue(32'h0, 32'h11, 1'b0, 1'b0, acc);
    issue(32'h4, 32'h22, 1'b0, 1'b0, acc);
    flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h8;
    @(negedge clk);
    chk("flush_req_ready", 32'(bus.req_ready), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    chk("flush_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    fetch(32'h8, 32'h33, 1'b0);
    drain();

    // Load and fetch to the same word in the same cycle
    ld_en = 1'b1; ld_addr = 10'd2; ld_data = 32'hAA;
    issue(32'h8, 32'h33, 1'b0, 1'b0, acc);
    ld_en = 1'b0;
    chk("rbw_accept", 32'(acc), 32'd1);
    issue(32'h8, 32'hAA, 1'b0, 1'b0, acc);
    chk("after_load_accept", 32'(acc), 32'd1);
    drain();

    // Asynchronous reset with two outstanding
    bus.rsp_ready = 1'b0;
    issue(32'h4, 32'h22, 1'b0, 1'b0, acc);
    issue(32'h0, 32'h11, 1'b0, 1'b0, acc);
    @(negedge clk);
    chk("pre_reset_valid", 32'(bus.rsp_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("async_rsp_instr", bus.rsp_instr, 32'd0);
    chk("async_req_ready", 32'(bus.req_ready), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rerelease_ready", 32'(bus.req_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    fetch(32'h4, 32'h22, 1'b0);
    fetch(32'h8, 32'hAA, 1'b0);
    fetch(32'hC, 32'h44, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
